// File: rtl/circle_pkg.sv
// Shared definitions for the midpoint circle rasteriser: FSM state codes,
// default screen size and the octant index range.
package circle_pkg;

  localparam int XRES_DEF = 160;
  localparam int YRES_DEF = 120;

  // State codes kept as plain constants so legacy blocks can compare against them.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLOT = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Octant sequencing: oct counts 0..7 within one PLOT burst.
  localparam logic [2:0] OCT_FIRST = 3'd0;
  localparam logic [2:0] OCT_LAST  = 3'd7;

endpackage

// File: rtl/midpoint_circle_gen_if.sv
// Request/pixel bundle between the circle-drawing controller (master) and the
// rasteriser (slave).
interface midpoint_circle_gen_if #(
  parameter int RW = 6
);
  logic          start;
  logic [7:0]    xc;
  logic [6:0]    yc;
  logic [RW-1:0] r;
  logic [7:0]    x;
  logic [6:0]    y;
  logic          valid;
  logic          busy;
  logic          done;

  modport master (output start, xc, yc, r, input x, y, valid, busy, done);
  modport slave  (input start, xc, yc, r, output x, y, valid, busy, done);
endinterface

// File: rtl/circle_octant_map.sv
// Maps the current midpoint offsets (xo,yo) onto one of the eight symmetric
// circle points and flags whether that point lies on screen.
// oct[0] swaps the offsets, oct[1] mirrors X, oct[2] mirrors Y.
module circle_octant_map #(
  parameter int XRES = 160,
  parameter int YRES = 120,
  parameter int RW   = 6
) (
  input  logic [7:0]    xc,
  input  logic [6:0]    yc,
  input  logic [RW-1:0] xo,
  input  logic [RW-1:0] yo,
  input  logic [2:0]    oct,
  output logic [7:0]    x,
  output logic [6:0]    y,
  output logic          on_screen
);

  logic signed [8:0] cx, cy, ox, oy, sx, sy;

  // Select offsets, add or subtract them from the centre, then clip.
  always_comb begin
    cx = $signed({1'b0, xc});
    cy = $signed({2'b00, yc});
    ox = oct[0] ? $signed(9'(yo)) : $signed(9'(xo));
    oy = oct[0] ? $signed(9'(xo)) : $signed(9'(yo));
    sx = oct[1] ? (cx - ox) : (cx + ox);
    sy = oct[2] ? (cy - oy) : (cy + oy);
    x  = sx[7:0];
    y  = sy[6:0];
    on_screen = (sx >= 0) && (sy >= 0) && (int'(sx) < XRES) && (int'(sy) < YRES);
  end

endmodule

// File: rtl/midpoint_circle_gen.sv
// Midpoint circle rasteriser: one octant point per PLOT cycle, one STEP cycle
// per midpoint iteration, then a single-cycle done pulse.
module midpoint_circle_gen
  import circle_pkg::*;
#(
  parameter int XRES = XRES_DEF,
  parameter int YRES = YRES_DEF,
  parameter int RW   = 6
) (
  input logic                  CLK50,
  input logic                  clearn,
  midpoint_circle_gen_if.slave bus
);

  logic [1:0]           state;
  logic [7:0]           xc_q;
  logic [6:0]           yc_q;
  logic [RW-1:0]        xo, yo;
  logic signed [8:0]    d;
  logic [2:0]           oct;

  logic signed [RW+1:0] xo_nx, yo_nx;
  logic signed [8:0]    d_nx;
  logic [7:0]           map_x;
  logic [6:0]           map_y;
  logic                 map_on;

  circle_octant_map #(.XRES(XRES), .YRES(YRES), .RW(RW)) u_map (
    .xc        (xc_q),
    .yc        (yc_q),
    .xo        (xo),
    .yo        (yo),
    .oct       (oct),
    .x         (map_x),
    .y         (map_y),
    .on_screen (map_on)
  );

  // Midpoint step from the current offsets; two spare bits let yo go to -1
  // (r=0) so the termination compare stays correct.
  always_comb begin
    xo_nx = {2'b00, xo} + (RW+2)'(1);
    yo_nx = {2'b00, yo} - ((d < 0) ? (RW+2)'(0) : (RW+2)'(1));
    if (d < 0)
      d_nx = d + $signed(9'({xo, 1'b0})) + 9'sd3;
    else
      d_nx = d + $signed(9'({xo, 1'b0})) - $signed(9'({yo, 1'b0})) + 9'sd5;
  end

  // FSM, latched request and midpoint state.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK50 or negedge clearn) begin
    if (!clearn) begin
      state <= S_IDLE;
      xc_q  <= '0;
      yc_q  <= '0;
      xo    <= '0;
      yo    <= '0;
      d     <= '0;
      oct   <= OCT_FIRST;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          xc_q  <= bus.xc;
          yc_q  <= bus.yc;
          xo    <= '0;
          yo    <= bus.r;
          d     <= 9'sd1 - $signed(9'(bus.r));
          oct   <= OCT_FIRST;
          state <= S_PLOT;
        end
        S_PLOT: begin
          if (oct == OCT_LAST) state <= S_STEP;
          else                 oct   <= oct + 3'd1;
        end
        S_STEP: begin
          d  <= d_nx;
          xo <= xo_nx[RW-1:0];
          yo <= yo_nx[RW-1:0];
          if (xo_nx > yo_nx) begin
            state <= S_DONE;
          end else begin
            oct   <= OCT_FIRST;
            state <= S_PLOT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs: pixel only while plotting, status from state.
  // NOTE: every output gets a default first so no path through always_comb infers a latch.
  always_comb begin
    bus.x     = '0;
    bus.y     = '0;
    bus.valid = 1'b0;
    if (state == S_PLOT) begin
      bus.x     = map_x;
      bus.y     = map_y;
      bus.valid = map_on;
    end
    bus.busy = (state != S_IDLE);
    bus.done = (state == S_DONE);
  end

endmodule

// File: tb/tb_midpoint_circle_gen.sv
// Scoreboard bench for midpoint_circle_gen: a behavioural midpoint model
// pushes the expected per-cycle outputs, and each falling edge pops one.
module tb_midpoint_circle_gen;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       valid;
    logic       busy;
    logic       done;
  } exp_t;

  logic CLK50  = 1'b0;
  logic clearn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  midpoint_circle_gen_if #(.RW(6)) bus ();

  midpoint_circle_gen #(.XRES(160), .YRES(120), .RW(6)) dut (
    .CLK50  (CLK50),
    .clearn (clearn),
    .bus    (bus)
  );

  always #10 CLK50 = ~CLK50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push_pt(input int sx, input int sy);
    exp_t e;
    e.x     = 8'(sx & 255);
    e.y     = 7'(sy & 127);
    e.valid = (sx >= 0) && (sx < 160) && (sy >= 0) && (sy < 120);
    e.busy  = 1'b1;
    e.done  = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_ctl(input logic busy, input logic done);
    exp_t e;
    e = '0;
    e.busy = busy;
    e.done = done;
    exp_q.push_back(e);
  endtask

  // Reference midpoint circle: 8 points + a step cycle per iteration, then done.
  task automatic expect_circle(input int cx, input int cy, input int rr, output int nsteps);
    int xo, yo, d;
    xo = 0; yo = rr; d = 1 - rr; nsteps = 0;
    do begin
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: push_pt(cx + xo, cy + yo);
          1: push_pt(cx + yo, cy + xo);
          2: push_pt(cx - xo, cy + yo);
          3: push_pt(cx - yo, cy + xo);
          4: push_pt(cx + xo, cy - yo);
          5: push_pt(cx + yo, cy - xo);
          6: push_pt(cx - xo, cy - yo);
          default: push_pt(cx - yo, cy - xo);
        endcase
      end
      push_ctl(1'b1, 1'b0);
      nsteps++;
      if (d < 0) d = d + 2 * xo + 3;
      else begin
        d = d + 2 * (xo - yo) + 5;
        yo--;
      end
      xo++;
    end while (xo <= yo);
    push_ctl(1'b1, 1'b1);
  endtask

  task automatic start_circle(input int cx, input int cy, input int rr);
    @(negedge CLK50);
    bus.start = 1'b1;
    bus.xc    = 8'(cx);
    bus.yc    = 7'(cy);
    bus.r     = 6'(rr);
  endtask

  // Pops one expectation per cycle; start is held until index release_at,
  // and xc/yc are scrambled at index change_at. done_at is 1-based from acceptance.
  task automatic drain(input string name, input int release_at, input int change_at,
                       output int done_at);
    exp_t e;
    int   i;
    i = 0;
    done_at = -1;
    while (exp_q.size() > 0) begin
      @(negedge CLK50);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, i),
            32'({bus.x, bus.y, bus.valid, bus.busy, bus.done}), 32'(e));
      if (bus.done && done_at < 0) done_at = i + 1;
      bus.start = (i < release_at);
      if (i == change_at) begin
        bus.xc = 8'd7;
        bus.yc = 7'd100;
      end
      i++;
    end
  endtask

  initial begin
    int n, n2, da;
    bus.start = 1'b1;
    bus.xc    = 8'd80;
    bus.yc    = 7'd60;
    bus.r     = 6'd1;

    // Reset held with start high: everything quiet.
    repeat (3) begin
      @(negedge CLK50);
      check("reset", 32'({bus.x, bus.y, bus.valid, bus.busy, bus.done}), 32'd0);
    end

    // Release reset with start high: the r=1 circle starts on the next edge.
    expect_circle(80, 60, 1, n);
    push_ctl(1'b0, 1'b0);
    clearn = 1'b1;
    drain("r1", 0, -1, da);
    check("r1_done_cycle", 32'(da), 32'(9 * n + 1));

    // r=2 and r=0 at the screen centre.
    start_circle(80, 60, 2);
    expect_circle(80, 60, 2, n);
    push_ctl(1'b0, 1'b0);
    drain("r2", 0, -1, da);
    check("r2_done_cycle", 32'(da), 32'd19);

    start_circle(80, 60, 0);
    expect_circle(80, 60, 0, n);
    push_ctl(1'b0, 1'b0);
    drain("r0", 0, -1, da);
    check("r0_done_cycle", 32'(da), 32'd10);

    // Clipping near the origin: same step count as an unclipped r=5 circle.
    start_circle(2, 2, 5);
    expect_circle(2, 2, 5, n);
    expect_circle(80, 60, 5, n2);
    exp_q = exp_q[0:9*n];
    push_ctl(1'b0, 1'b0);
    drain("clip", 0, -1, da);
    check("clip_done_cycle", 32'(da), 32'(9 * n2 + 1));

    // Centre inputs changed mid-circle must not disturb the output.
    start_circle(40, 30, 20);
    expect_circle(40, 30, 20, n);
    push_ctl(1'b0, 1'b0);
    drain("xc_chg", 0, 5, da);
    check("xc_chg_done_cycle", 32'(da), 32'(9 * n + 1));

    // start held through DONE: restart only after one IDLE cycle.
    start_circle(80, 60, 1);
    expect_circle(80, 60, 1, n);
    push_ctl(1'b0, 1'b0);
    expect_circle(80, 60, 1, n);
    push_ctl(1'b0, 1'b0);
    drain("hold", 12, -1, da);

    // Reset pulse at cycle 5 of a large circle: no done, back in IDLE.
    start_circle(80, 60, 59);
    expect_circle(80, 60, 59, n);
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      @(negedge CLK50);
      bus.start = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("r59[%0d]", i),
            32'({bus.x, bus.y, bus.valid, bus.busy, bus.done}), 32'(e));
    end
    #2 clearn = 1'b0;
    #1 check("mid_reset", 32'({bus.x, bus.y, bus.valid, bus.busy, bus.done}), 32'd0);
    exp_q.delete();
    @(negedge CLK50);
    clearn = 1'b1;
    repeat (20) begin
      @(negedge CLK50);
      check("post_reset_idle", 32'({bus.valid, bus.busy, bus.done}), 32'd0);
    end

    // A few random on-screen circles.
    for (int k = 0; k < 4; k++) begin
      int cx, cy, rr;
      cx = $urandom_range(159);
      cy = $urandom_range(119);
      rr = $urandom_range(63);
      start_circle(cx, cy, rr);
      expect_circle(cx, cy, rr, n);
      push_ctl(1'b0, 1'b0);
      drain($sformatf("rnd%0d", k), 0, -1, da);
      check($sformatf("rnd%0d_done_cycle", k), 32'(da), 32'(9 * n + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/midpoint_circle_gen.md
# midpoint_circle_gen

Midpoint circle rasteriser for the 160x120 VGA path. It emits one pixel coordinate per clock for every point on a circle of radius `r` centred on (`xc`,`yc`), then pulses `done`. It sits directly upstream of the circle-drawing controller, which holds `start` high while in its plotting state, muxes `x`/`y` to the VGA adapter, and leaves that state on `done`.

## Interface
Parameters:
- `XRES`, 160: screen width; the valid X range is 0..XRES-1.
- `YRES`, 120: screen height; the valid Y range is 0..YRES-1.
- `RW`, 6: radius width in bits.

Ports:
- `CLK50`  in  1  system clock; all state changes on the rising edge.
- `clearn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level request. Sampled only in IDLE.
- `xc`  in  8  centre X. Latched when `start` is accepted.
- `yc`  in  7  centre Y. Latched when `start` is accepted.
- `r`  in  RW  radius. Latched when `start` is accepted. `r=0` is legal.
- `x`  out  8  pixel X.
- `y`  out  7  pixel Y.
- `valid`  out  1  `x`/`y` is an on-screen circle point this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse marking the end of the circle.

## Operation
- States: IDLE, PLOT, STEP, DONE.
- IDLE:
  - If `start`=1 at the clock edge: latch `xc`, `yc`, `r`.
  - Initialise `xo`=0, `yo`=r, `d`=1-r, `oct`=0.
  - Go to PLOT.
- PLOT (8 cycles, `oct` = 0..7): output one octant point per cycle, in this order:
  - (xc+xo, yc+yo), (xc+yo, yc+xo), (xc-xo, yc+yo), (xc-yo, yc+xo)
  - (xc+xo, yc-yo), (xc+yo, yc-xo), (xc-xo, yc-yo), (xc-yo, yc-xo)
  - When `oct`=7, go to STEP.
- STEP (1 cycle, `valid`=0). Update using the old `xo`/`yo`:
  - If d<0: d += 2·xo+3; xo++.
  - Else: d += 2·(xo-yo)+5; xo++; yo--.
  - If the new xo > new yo, go to DONE; otherwise reset `oct`=0 and go to PLOT.
- DONE: `done`=1 for one cycle, then go to IDLE unconditionally.
  - A `start` still high in the DONE cycle is ignored.
  - A restart requires `start` high in an IDLE cycle.
- Duplicate points (where xo=0 or xo=yo) are emitted as-is. They are not filtered.
- `start` is ignored outside IDLE. Inputs may change freely after they are latched.

Arithmetic and widths:
- `d` is 9-bit signed.
- Octant sums use 9-bit signed: centre zero-extended, offset zero-extended, then add or subtract.
- Clipping: `valid`=0 if the sum is <0, or X ≥ XRES, or Y ≥ YRES. The cycle is still consumed.
- `x`/`y` carry the low 8/7 bits of the sums.

Outputs by state:
- In IDLE, STEP and DONE: `x`=0, `y`=0, `valid`=0.
- In PLOT: `x`/`y` are decoded combinationally from registered state. There is no extra pipeline stage.

## Timing
- Reset values: state=IDLE, `x`=0, `y`=0, `valid`=0, `busy`=0, `done`=0. All internal registers are 0.
- `clearn` low mid-circle: return to IDLE immediately. No `done` is produced, and the remaining points are discarded.
- Latency: the first point appears in the cycle after the accepting edge.
- A circle of N midpoint steps takes 9·N cycles of PLOT+STEP, followed by 1 DONE cycle.
- `done` is asserted in cycle 9·N+1 after the accepting edge.
- Throughput: 8 points per 9 cycles.
- `busy` is high from the cycle after acceptance through DONE inclusive.

## Structure
- Shared package `circle_pkg`:
  - state encoding,
  - `XRES`/`YRES` defaults,
  - octant index constants.
- One sub-module, `circle_octant_map`, which is purely combinational:
  - inputs: `xc`, `yc`, `xo`, `yo`, `oct`;
  - outputs: `x`, `y`, on-screen flag.
- FSM, offset/decision registers and the step update live in the top level.

## Test plan
- Reset: hold `clearn` low with `start`=1. Expect all outputs 0. Release reset: a circle starts on the next edge.
- r=1, centre (80,60):
  - Expect 8 valid points: (80,61), (81,60), (80,61), (79,60), (80,59), (81,60), (80,59), (79,60).
  - Then 1 STEP cycle; `done` asserted 10 cycles after acceptance; `busy` falls after it.
- r=2, centre (80,60):
  - Step 1 offsets (0,2); step 2 offsets (1,2).
  - `done` asserted 19 cycles after acceptance; 16 valid pulses.
- r=0: 8 valid cycles at (80,60), then STEP and DONE, with `done` asserted at cycle 10.
- Clipping, centre (2,2), r=5:
  - Points with negative X or Y have `valid`=0 while still consuming cycles.
  - The step count is unchanged relative to centre (80,60).
- Control corner cases:
  - Pulse `clearn` low at cycle 5 of a circle with r=59: no `done`, and the block is back in IDLE.
  - Hold `start` high through DONE: the circle restarts only after one IDLE cycle.
  - Change `xc` mid-circle: the output is unaffected.
